// File: rtl/block_state_ctrl_pkg.sv
// Shared breakout constants and the brick-state controller state type.
// Imported by the controller; the renderer and the RAM size themselves from the same values.
package block_state_ctrl_pkg;

    localparam int BSC_NUM_BLOCKS       = 73;
    localparam int BSC_ADDR_WIDTH       = 7;
    localparam int BSC_SCORE_WIDTH      = 16;
    localparam int BSC_POINTS_PER_BLOCK = 10;

    typedef enum logic [1:0] {
        ST_SWEEP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_EVAL  = 2'd3
    } bsc_state_t;

endpackage

// File: rtl/block_state_ctrl.sv
// Brick-state RAM port A owner: refills the bricks, turns hit requests into
// read-and-clear operations, and keeps the brick count and saturating score.
module block_state_ctrl
    import block_state_ctrl_pkg::*;
#(
    parameter int NUM_BLOCKS       = BSC_NUM_BLOCKS,
    parameter int ADDR_WIDTH       = BSC_ADDR_WIDTH,
    parameter int SCORE_WIDTH      = BSC_SCORE_WIDTH,
    parameter int POINTS_PER_BLOCK = BSC_POINTS_PER_BLOCK
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_hit_req,
    input  logic [ADDR_WIDTH-1:0]  i_hit_addr,
    output logic                   o_hit_ack,
    output logic                   o_hit_was_present,
    input  logic                   i_level_start,
    output logic                   o_busy,
    output logic [ADDR_WIDTH-1:0]  o_blocks_left,
    output logic                   o_level_clear,
    output logic [SCORE_WIDTH-1:0] o_score,
    output logic [ADDR_WIDTH-1:0]  o_mem_a_addr,
    output logic                   o_mem_a_write_enable,
    output logic                   o_mem_a_in,
    input  logic                   i_mem_a_out
);

    localparam logic [ADDR_WIDTH:0]   LP_NUM_BLOCKS_EXT = (ADDR_WIDTH+1)'(NUM_BLOCKS);
    localparam logic [ADDR_WIDTH-1:0] LP_NUM_BLOCKS     = ADDR_WIDTH'(NUM_BLOCKS);
    localparam logic [SCORE_WIDTH:0]  LP_POINTS         = (SCORE_WIDTH+1)'(POINTS_PER_BLOCK);

    bsc_state_t             r_state;
    bsc_state_t             w_next_state;
    logic [ADDR_WIDTH-1:0]  r_sweep_addr;
    logic [ADDR_WIDTH-1:0]  r_hit_addr;
    logic                   r_in_range;
    logic                   r_pending_start;
    logic [ADDR_WIDTH-1:0]  r_blocks_left;
    logic [SCORE_WIDTH-1:0] r_score;

    logic                   w_busy;
    logic                   w_sweep_last;
    logic                   w_sweep_in_range;
    logic                   w_hit_in_range;
    logic                   w_hit_present;
    logic [SCORE_WIDTH:0]   w_score_sum;

    assign w_busy           = (r_state == ST_SWEEP);
    assign w_sweep_last     = (r_sweep_addr == '1);
    assign w_sweep_in_range = ({1'b0, r_sweep_addr} < LP_NUM_BLOCKS_EXT);
    assign w_hit_in_range   = ({1'b0, i_hit_addr} < LP_NUM_BLOCKS_EXT);
    // Out-of-range hits never touch the RAM, so whatever it returns is ignored.
    assign w_hit_present    = r_in_range & i_mem_a_out;
    assign w_score_sum      = {1'b0, r_score} + LP_POINTS;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_SWEEP;
            r_sweep_addr    <= '0;
            r_hit_addr      <= '0;
            r_in_range      <= 1'b0;
            r_pending_start <= 1'b0;
            r_blocks_left   <= '0;
            r_score         <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_SWEEP: begin
                    r_sweep_addr <= r_sweep_addr + 1'b1;
                    if (w_sweep_last) r_blocks_left <= LP_NUM_BLOCKS;
                end
                ST_IDLE: begin
                    if (i_level_start || r_pending_start) begin
                        r_pending_start <= 1'b0;
                        r_sweep_addr    <= '0;
                    end else if (i_hit_req) begin
                        r_hit_addr <= i_hit_addr;
                        r_in_range <= w_hit_in_range;
                    end
                end
                ST_CLEAR: begin
                    if (i_level_start) r_pending_start <= 1'b1;
                end
                ST_EVAL: begin
                    if (i_level_start) r_pending_start <= 1'b1;
                    if (w_hit_present) begin
                        if (r_blocks_left != '0) r_blocks_left <= r_blocks_left - 1'b1;
                        r_score <= w_score_sum[SCORE_WIDTH] ? '1 : w_score_sum[SCORE_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state         = r_state;
        o_mem_a_addr         = '0;
        o_mem_a_write_enable = 1'b0;
        o_mem_a_in           = 1'b0;
        o_hit_ack            = 1'b0;
        o_hit_was_present    = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                o_mem_a_addr         = r_sweep_addr;
                o_mem_a_write_enable = 1'b1;
                o_mem_a_in           = w_sweep_in_range;
                if (w_sweep_last) w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_level_start || r_pending_start) w_next_state = ST_SWEEP;
                else if (i_hit_req)                   w_next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                // Read-first RAM: the old bit appears next cycle while this write clears it.
                o_mem_a_addr         = r_hit_addr;
                o_mem_a_write_enable = r_in_range;
                w_next_state         = ST_EVAL;
            end
            ST_EVAL: begin
                o_hit_ack         = 1'b1;
                o_hit_was_present = w_hit_present;
                w_next_state      = ST_IDLE;
            end
            default: w_next_state = ST_SWEEP;
        endcase
    end

    assign o_busy        = w_busy;
    assign o_blocks_left = r_blocks_left;
    assign o_level_clear = (r_blocks_left == '0) && !w_busy;
    assign o_score       = r_score;

endmodule

// File: tb/tb_block_state_ctrl.sv
// Self-checking bench for block_state_ctrl with a read-first RAM model and a
// brick/score reference model; hit results are scoreboarded through queues.
module tb_block_state_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default parameters)
    logic        reset = 1'b1;
    logic        hit_req = 1'b0;
    logic [6:0]  hit_addr = '0;
    logic        level_start = 1'b0;
    logic        hit_ack, hit_was_present, busy, level_clear;
    logic [6:0]  blocks_left, mem_a_addr;
    logic [15:0] score;
    logic        mem_we, mem_in;
    logic        mem_out;
    logic        ram [128];

    block_state_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_hit_req(hit_req), .i_hit_addr(hit_addr),
        .o_hit_ack(hit_ack), .o_hit_was_present(hit_was_present),
        .i_level_start(level_start), .o_busy(busy), .o_blocks_left(blocks_left),
        .o_level_clear(level_clear), .o_score(score), .o_mem_a_addr(mem_a_addr),
        .o_mem_a_write_enable(mem_we), .o_mem_a_in(mem_in), .i_mem_a_out(mem_out)
    );

    always @(posedge clk) begin
        mem_out <= ram[mem_a_addr];
        if (mem_we) ram[mem_a_addr] <= mem_in;
    end

    // Saturation DUT (5-bit score)
    logic       s_reset = 1'b1;
    logic       s_req = 1'b0;
    logic [6:0] s_addr = '0;
    logic       s_ack, s_present, s_busy, s_level_clear;
    logic [6:0] s_blocks_left, s_mem_addr;
    logic [4:0] s_score;
    logic       s_mem_we, s_mem_in;
    logic       s_mem_out;
    logic       s_ram [128];

    block_state_ctrl #(.SCORE_WIDTH(5), .POINTS_PER_BLOCK(10)) dut_sat (
        .i_clk(clk), .i_reset(s_reset), .i_hit_req(s_req), .i_hit_addr(s_addr),
        .o_hit_ack(s_ack), .o_hit_was_present(s_present),
        .i_level_start(1'b0), .o_busy(s_busy), .o_blocks_left(s_blocks_left),
        .o_level_clear(s_level_clear), .o_score(s_score), .o_mem_a_addr(s_mem_addr),
        .o_mem_a_write_enable(s_mem_we), .o_mem_a_in(s_mem_in), .i_mem_a_out(s_mem_out)
    );

    always @(posedge clk) begin
        s_mem_out <= s_ram[s_mem_addr];
        if (s_mem_we) s_ram[s_mem_addr] <= s_mem_in;
    end

    int   checks = 0;
    int   errors = 0;
    bit   model_bricks [128];
    int   model_left  = 0;
    int   model_score = 0;
    logic exp_present_q [$];
    int   exp_sat_score_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_sweep();
        for (int i = 0; i < 128; i++) model_bricks[i] = (i < 73);
        model_left = 73;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_score = 0;
        model_left  = 0;
        checks++;
        if (busy !== 1'b1 || blocks_left !== 7'd0 || score !== 16'd0 ||
            level_clear !== 1'b0 || hit_ack !== 1'b0 || mem_a_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b left=%0d score=%0d clr=%b ack=%b addr=%0d want 1/0/0/0/0/0",
                     busy, blocks_left, score, level_clear, hit_ack, mem_a_addr);
        end
    endtask

    // Expects to start in the first sweep cycle (address 0); ends in IDLE.
    task automatic test_sweep();
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (busy !== 1'b1 || mem_we !== 1'b1 || mem_a_addr !== 7'(i) || mem_in !== (i < 73)) begin
                errors++;
                $display("FAIL sweep_write[%0d]: busy=%b we=%b addr=%0d in=%b want busy=1 we=1 addr=%0d in=%b",
                         i, busy, mem_we, mem_a_addr, mem_in, i, (i < 73));
            end
            step();
        end
        model_sweep();
        checks++;
        if (busy !== 1'b0 || blocks_left !== 7'(model_left) || level_clear !== 1'b0 ||
            score !== 16'(model_score)) begin
            errors++;
            $display("FAIL sweep_done: busy=%b left=%0d clr=%b score=%0d want 0/%0d/0/%0d",
                     busy, blocks_left, level_clear, score, model_left, model_score);
        end
    endtask

    task automatic wait_ack(input int budget, output int cycles, output bit got);
        cycles = 0;
        got    = 1'b0;
        while (cycles < budget && !got) begin
            step();
            cycles++;
            if (hit_ack === 1'b1) got = 1'b1;
        end
    endtask

    task automatic compare_ack(input string name, input bit got);
        logic exp;
        exp = exp_present_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_ack_timeout: got no ack want ack", name);
        end else if (hit_was_present !== exp) begin
            errors++;
            $display("FAIL %s_present: got %b want %b", name, hit_was_present, exp);
        end
    endtask

    task automatic compare_counters(input string name);
        checks++;
        if (blocks_left !== 7'(model_left) || score !== 16'(model_score) ||
            level_clear !== (model_left == 0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL %s_counters: left=%0d score=%0d clr=%b want %0d/%0d/%b",
                     name, blocks_left, score, level_clear, model_left, model_score, (model_left == 0));
        end
    endtask

    task automatic model_apply_hit(input logic [6:0] addr);
        if (model_bricks[addr]) begin
            model_bricks[addr] = 1'b0;
            if (model_left > 0) model_left--;
            model_score = (model_score + 10 > 65535) ? 65535 : model_score + 10;
        end
    endtask

    // Single hit issued from IDLE with exact N+1 / N+2 / N+3 timing checks.
    task automatic do_hit(input string name, input logic [6:0] addr);
        int cycles;
        bit got;
        logic exp_we;
        exp_we = (addr < 7'd73);
        exp_present_q.push_back(model_bricks[addr]);
        hit_req  = 1'b1;
        hit_addr = addr;
        step();
        checks++;
        if (hit_ack !== 1'b0 || mem_a_addr !== addr || mem_we !== exp_we || mem_in !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear_cycle: ack=%b addr=%0d we=%b in=%b want 0/%0d/%b/0",
                     name, hit_ack, mem_a_addr, mem_we, mem_in, addr, exp_we);
        end
        step();
        got = (hit_ack === 1'b1);
        checks++;
        if (!got || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL %s_ack_timing: ack=%b we=%b at N+2 want ack=1 we=0", name, hit_ack, mem_we);
            if (!got) wait_ack(20, cycles, got);
        end
        compare_ack(name, got);
        hit_req = 1'b0;
        model_apply_hit(addr);
        step();
        compare_counters(name);
    endtask

    task automatic test_reset();
        apply_reset();
        test_sweep();
    endtask

    task automatic test_hit_basic();
        do_hit("hit5", 7'd5);
        do_hit("rehit5", 7'd5);
    endtask

    task automatic test_out_of_range();
        do_hit("hit100", 7'd100);
    endtask

    task automatic test_start_priority();
        int cycles;
        bit got;
        level_start = 1'b1;
        hit_req     = 1'b1;
        hit_addr    = 7'd3;
        model_sweep();
        exp_present_q.push_back(model_bricks[3]);
        step();
        level_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_a_addr !== 7'd0 || hit_ack !== 1'b0) begin
            errors++;
            $display("FAIL prio_sweep_first: busy=%b addr=%0d ack=%b want 1/0/0", busy, mem_a_addr, hit_ack);
        end
        wait_ack(200, cycles, got);
        checks++;
        if (cycles != 130) begin
            errors++;
            $display("FAIL prio_ack_latency: got %0d cycles want 130", cycles);
        end
        compare_ack("prio", got);
        hit_req = 1'b0;
        model_apply_hit(7'd3);
        step();
        compare_counters("prio");
    endtask

    task automatic test_clear_all();
        int cycles;
        bit got;
        apply_reset();
        test_sweep();
        for (int a = 0; a < 72; a++) do_hit("sweep_hit", 7'(a));
        checks++;
        if (level_clear !== 1'b0 || blocks_left !== 7'd1) begin
            errors++;
            $display("FAIL before_last: clr=%b left=%0d want 0/1", level_clear, blocks_left);
        end
        exp_present_q.push_back(model_bricks[72]);
        hit_req  = 1'b1;
        hit_addr = 7'd72;
        step();
        level_start = 1'b1;
        step();
        level_start = 1'b0;
        got = (hit_ack === 1'b1);
        if (!got) wait_ack(20, cycles, got);
        compare_ack("last", got);
        hit_req = 1'b0;
        model_apply_hit(7'd72);
        step();
        checks++;
        if (level_clear !== 1'b1 || blocks_left !== 7'd0 || score !== 16'd730 || busy !== 1'b0) begin
            errors++;
            $display("FAIL level_clear: clr=%b left=%0d score=%0d busy=%b want 1/0/730/0",
                     level_clear, blocks_left, score, busy);
        end
        compare_counters("last");
        step();
        checks++;
        if (busy !== 1'b1 || mem_a_addr !== 7'd0) begin
            errors++;
            $display("FAIL pending_start: busy=%b addr=%0d want 1/0", busy, mem_a_addr);
        end
        test_sweep();
    endtask

    task automatic test_reset_mid_ops();
        level_start = 1'b1;
        step();
        level_start = 1'b0;
        repeat (40) step();
        checks++;
        if (mem_a_addr !== 7'd40 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_addr: addr=%0d busy=%b want 40/1", mem_a_addr, busy);
        end
        apply_reset();
        test_sweep();
        hit_req  = 1'b1;
        hit_addr = 7'd10;
        step();
        reset   = 1'b1;
        hit_req = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if (hit_ack !== 1'b0 || busy !== 1'b1 || mem_a_addr !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_hit: ack=%b busy=%b addr=%0d want 0/1/0", hit_ack, busy, mem_a_addr);
        end
        model_score = 0;
        model_left  = 0;
        test_sweep();
    endtask

    task automatic test_saturation();
        int n;
        int exp_score;
        int exp;
        s_reset = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (s_busy !== 1'b0 || s_blocks_left !== 7'd73 || s_score !== 5'd0 || n != 128) begin
            errors++;
            $display("FAIL sat_sweep: busy=%b left=%0d score=%0d cycles=%0d want 0/73/0/128",
                     s_busy, s_blocks_left, s_score, n);
        end
        exp_score = 0;
        for (int k = 0; k < 4; k++) begin
            exp_score = (exp_score + 10 > 31) ? 31 : exp_score + 10;
            exp_sat_score_q.push_back(exp_score);
            s_req  = 1'b1;
            s_addr = 7'(k);
            n = 0;
            while (s_ack !== 1'b1 && n < 10) begin
                step();
                n++;
            end
            checks++;
            if (s_ack !== 1'b1 || s_present !== 1'b1) begin
                errors++;
                $display("FAIL sat_ack[%0d]: ack=%b present=%b want 1/1", k, s_ack, s_present);
            end
            s_req = 1'b0;
            step();
            exp = exp_sat_score_q.pop_front();
            checks++;
            if (s_score !== 5'(exp)) begin
                errors++;
                $display("FAIL sat_score[%0d]: got %0d want %0d", k, s_score, exp);
            end
        end
    endtask

    initial begin
        step();
        test_reset();
        test_hit_basic();
        test_out_of_range();
        test_start_priority();
        test_clear_all();
        test_reset_mid_ops();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
